// File: rtl/pathfinding_pkg.sv
// Shared A* pipeline types: the 272-bit node record, the empty-slot marker and the expander state set.
package pathfinding_pkg;

  localparam int          NUM_CHILDREN = 6;
  localparam logic [15:0] NULL_ID      = 16'hFFFF;

  typedef struct packed {
    logic [15:0]                   x;
    logic [15:0]                   y;
    logic [15:0]                   node_id;
    logic [15:0]                   parent_node_id;
    logic [15:0]                   current_cost;
    logic [NUM_CHILDREN-1:0][15:0] child_id;
    logic [NUM_CHILDREN-1:0][15:0] distance;
  } node_info;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SCAN,
    EMIT,
    FINISH
  } expand_state_t;

endpackage

// File: rtl/sat_add16.sv
// Unsigned 16+16 adder clamping to 16'hFFFF on carry-out.
// Latency: combinational; backpressure: none.
module sat_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [16:0] wide;

  assign wide = {1'b0, a} + {1'b0, b};
  assign sum  = wide[16] ? 16'hFFFF : wide[15:0];

endmodule

// File: rtl/node_expander.sv
// Goal test then child expansion of one node record; one candidate per child_valid/child_ready handshake.
// Latency: goal_found 1 cycle after accept, first child 2 cycles after; backpressure holds EMIT with child_* stable.
module node_expander
  import pathfinding_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_pulse,
  input  node_info    goal_data,
  input  logic        node_valid,
  input  node_info    node_data,
  output logic        node_ready,
  output logic        child_valid,
  input  logic        child_ready,
  output logic [15:0] child_id,
  output logic [15:0] child_parent_id,
  output logic [15:0] child_g,
  output logic        goal_found,
  output logic        expand_done,
  output logic [2:0]  child_count
);

  expand_state_t state, state_nxt;
  node_info      node_q, node_nxt;
  logic [15:0]   goal_id;
  logic [2:0]    idx, idx_nxt;
  logic [2:0]    cnt, cnt_nxt;

  logic          cv_nxt, gf_nxt, ed_nxt;
  logic [15:0]   cid_nxt, cpid_nxt, cg_nxt;

  logic [15:0]   sel_id, sel_dist, sel_g;
  logic          slot_ok, last_slot;
  logic          unused_bits;

  // 6:1 slot mux over the captured record
  always_comb begin
    sel_id   = NULL_ID;
    sel_dist = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      if (idx == 3'(i)) begin
        sel_id   = node_q.child_id[i];
        sel_dist = node_q.distance[i];
      end
    end
  end

  assign slot_ok   = (sel_id != NULL_ID) && (sel_id != node_q.parent_node_id);
  assign last_slot = (idx == 3'(NUM_CHILDREN - 1));

  sat_add16 u_sat_add16 (
    .a   (node_q.current_cost),
    .b   (sel_dist),
    .sum (sel_g)
  );

  // Holding off node_ready while goal_found is up keeps the next accept one cycle clear of the pulse
  assign node_ready  = (state == IDLE) && !goal_found;
  assign child_count = cnt;

  always_comb begin
    state_nxt = state;
    node_nxt  = node_q;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    cv_nxt    = child_valid;
    cid_nxt   = child_id;
    cpid_nxt  = child_parent_id;
    cg_nxt    = child_g;
    gf_nxt    = 1'b0;
    ed_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (node_valid && node_ready) begin
          node_nxt  = node_data;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (node_q.node_id == goal_id) begin
          gf_nxt    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (slot_ok) begin
          cid_nxt   = sel_id;
          cpid_nxt  = node_q.node_id;
          cg_nxt    = sel_g;
          cv_nxt    = 1'b1;
          state_nxt = EMIT;
        end else if (last_slot) begin
          ed_nxt    = 1'b1;
          state_nxt = FINISH;
        end else begin
          idx_nxt   = idx + 3'd1;
        end
      end
      EMIT: begin
        if (child_valid && child_ready) begin
          cv_nxt  = 1'b0;
          cnt_nxt = cnt + 3'd1;
          if (last_slot) begin
            ed_nxt    = 1'b1;
            state_nxt = FINISH;
          end else begin
            idx_nxt   = idx + 3'd1;
            state_nxt = SCAN;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A new search aborts whatever is in flight, including pulses not yet shown
    if (start_pulse) begin
      state_nxt = IDLE;
      cv_nxt    = 1'b0;
      gf_nxt    = 1'b0;
      ed_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      node_q          <= '0;
      idx             <= '0;
      cnt             <= '0;
      goal_id         <= NULL_ID;
      child_valid     <= 1'b0;
      child_id        <= '0;
      child_parent_id <= '0;
      child_g         <= '0;
      goal_found      <= 1'b0;
      expand_done     <= 1'b0;
    end else begin
      state           <= state_nxt;
      node_q          <= node_nxt;
      idx             <= idx_nxt;
      cnt             <= cnt_nxt;
      child_valid     <= cv_nxt;
      child_id        <= cid_nxt;
      child_parent_id <= cpid_nxt;
      child_g         <= cg_nxt;
      goal_found      <= gf_nxt;
      expand_done     <= ed_nxt;
      if (start_pulse) begin
        goal_id <= goal_data.node_id;
      end
    end
  end

  assign unused_bits = ^{node_q.x, node_q.y, goal_data.x, goal_data.y,
                         goal_data.parent_node_id, goal_data.current_cost,
                         goal_data.child_id, goal_data.distance};

endmodule

// File: tb/tb_node_expander.sv
// Directed bench for node_expander: list-based expansion model plus per-cycle compare monitor.
module tb_node_expander;
  import pathfinding_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_pulse;
  node_info    goal_data;
  logic        node_valid;
  node_info    node_data;
  logic        node_ready;
  logic        child_valid;
  logic        child_ready;
  logic [15:0] child_id;
  logic [15:0] child_parent_id;
  logic [15:0] child_g;
  logic        goal_found;
  logic        expand_done;
  logic [2:0]  child_count;

  always #5 clk = ~clk;

  node_expander dut (
    .clk             (clk),
    .reset           (reset),
    .start_pulse     (start_pulse),
    .goal_data       (goal_data),
    .node_valid      (node_valid),
    .node_data       (node_data),
    .node_ready      (node_ready),
    .child_valid     (child_valid),
    .child_ready     (child_ready),
    .child_id        (child_id),
    .child_parent_id (child_parent_id),
    .child_g         (child_g),
    .goal_found      (goal_found),
    .expand_done     (expand_done),
    .child_count     (child_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] pid;
    logic [15:0] g;
  } cand_t;

  // Model: what each node must produce, derived from the expansion rules
  cand_t       exp_q[$];
  int          exp_done_q[$];
  int          exp_goal   = 0;
  logic [15:0] model_goal = 16'hFFFF;
  cand_t       log_q[$];

  task automatic model_node(input node_info n);
    int    k;
    int    s;
    cand_t c;
    k = 0;
    if (n.node_id == model_goal) begin
      exp_goal++;
      return;
    end
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      if (n.child_id[i] != NULL_ID && n.child_id[i] != n.parent_node_id) begin
        s     = int'(n.current_cost) + int'(n.distance[i]);
        c.id  = n.child_id[i];
        c.pid = n.node_id;
        c.g   = (s > 65535) ? 16'hFFFF : 16'(s);
        exp_q.push_back(c);
        k++;
      end
    end
    exp_done_q.push_back(k);
  endtask

  function automatic node_info mk(input logic [15:0] id, input logic [15:0] par, input logic [15:0] cost,
                                  input logic [15:0] c0, input logic [15:0] d0,
                                  input logic [15:0] c1, input logic [15:0] d1,
                                  input logic [15:0] c2, input logic [15:0] d2,
                                  input logic [15:0] c3, input logic [15:0] d3,
                                  input logic [15:0] c4, input logic [15:0] d4,
                                  input logic [15:0] c5, input logic [15:0] d5);
    node_info n;
    n                = '0;
    n.x              = 16'h1111;
    n.y              = id;
    n.node_id        = id;
    n.parent_node_id = par;
    n.current_cost   = cost;
    n.child_id[0] = c0; n.distance[0] = d0;
    n.child_id[1] = c1; n.distance[1] = d1;
    n.child_id[2] = c2; n.distance[2] = d2;
    n.child_id[3] = c3; n.distance[3] = d3;
    n.child_id[4] = c4; n.distance[4] = d4;
    n.child_id[5] = c5; n.distance[5] = d5;
    return n;
  endfunction

  // Compare process
  logic        prev_stall = 1'b0;
  logic [15:0] prev_id, prev_pid, prev_g;
  cand_t       mon_e, mon_c;
  int          mon_d;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", child_valid, 1);
        check("hold_id", child_id, prev_id);
        check("hold_parent", child_parent_id, prev_pid);
        check("hold_g", child_g, prev_g);
      end
      if (child_valid && child_ready) begin
        check("child_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("child_id", child_id, mon_e.id);
          check("child_parent_id", child_parent_id, mon_e.pid);
          check("child_g", child_g, mon_e.g);
        end
        mon_c.id  = child_id;
        mon_c.pid = child_parent_id;
        mon_c.g   = child_g;
        log_q.push_back(mon_c);
      end
      if (goal_found) begin
        check("goal_expected", exp_goal > 0, 1);
        if (exp_goal > 0) exp_goal--;
      end
      if (expand_done) begin
        check("done_expected", exp_done_q.size() != 0, 1);
        if (exp_done_q.size() != 0) begin
          mon_d = exp_done_q.pop_front();
          check("child_count", child_count, mon_d);
        end
      end
      prev_stall = child_valid && !child_ready && !start_pulse;
      prev_id    = child_id;
      prev_pid   = child_parent_id;
      prev_g     = child_g;
    end
  end

  // Present one node, then report the cycle index (0 = CHECK cycle) of the terminating pulse
  task automatic run_node(input node_info n, output int ev, output bit goal, output int first_cv,
                          output logic [2:0] cnt, output logic rdy_ev);
    @(posedge clk); #1;
    check("node_ready_before_accept", node_ready, 1);
    model_node(n);
    node_valid = 1'b1;
    node_data  = n;
    @(posedge clk); #1;
    node_valid = 1'b0;
    ev = -1; goal = 1'b0; first_cv = -1; cnt = '0; rdy_ev = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (first_cv < 0 && child_valid) first_cv = c;
      if (goal_found || expand_done) begin
        ev     = c;
        goal   = goal_found;
        cnt    = child_count;
        rdy_ev = node_ready;
        break;
      end
    end
    check("node_finished_in_budget", ev >= 0, 1);
  endtask

  task automatic wait_child_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (child_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  int         ev, fcv;
  bit         goal;
  logic [2:0] cnt;
  logic       rdy_ev;
  node_info   n;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    start_pulse = 1'b0;
    goal_data   = '0;
    node_valid  = 1'b0;
    node_data   = '0;
    child_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset / idle outputs
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_node_ready", node_ready, 1);
      check("rst_child_valid", child_valid, 0);
      check("rst_goal_found", goal_found, 0);
      check("rst_expand_done", expand_done, 0);
      check("rst_child_id", child_id, 0);
      check("rst_child_parent_id", child_parent_id, 0);
      check("rst_child_g", child_g, 0);
      check("rst_child_count", child_count, 0);
    end

    // Goal match
    @(posedge clk); #1;
    start_pulse = 1'b1;
    goal_data   = mk(7, 0, 0, 1,1, 2,2, 3,3, 4,4, 5,5, 6,6);
    model_goal  = 16'd7;
    @(posedge clk); #1;
    start_pulse = 1'b0;
    run_node(mk(7, 0, 0, 1,1, 2,2, 3,3, 4,4, 5,5, 6,6), ev, goal, fcv, cnt, rdy_ev);
    check("goal_pulse", goal, 1);
    check("goal_cycle", ev, 1);
    check("goal_no_child", fcv, -1);
    check("goal_node_ready_low", rdy_ev, 0);
    @(negedge clk);
    check("goal_pulse_single", goal_found, 0);
    check("goal_node_ready_back", node_ready, 1);

    // Mixed slots
    log_q.delete();
    run_node(mk(3, 2, 10, 5,4, 16'hFFFF,0, 2,1, 9,20, 16'hFFFF,0, 11,0), ev, goal, fcv, cnt, rdy_ev);
    check("mixed_first_cv", fcv, 2);
    check("mixed_done_cycle", ev, 10);
    check("mixed_count", cnt, 3);
    check("mixed_n", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("mixed_id0", log_q[0].id, 5);  check("mixed_g0", log_q[0].g, 14);
      check("mixed_id1", log_q[1].id, 9);  check("mixed_g1", log_q[1].g, 30);
      check("mixed_id2", log_q[2].id, 11); check("mixed_g2", log_q[2].g, 10);
      check("mixed_pid", log_q[2].pid, 3);
    end

    // All slots null
    run_node(mk(20, 0, 0, 16'hFFFF,0, 16'hFFFF,0, 16'hFFFF,0, 16'hFFFF,0, 16'hFFFF,0, 16'hFFFF,0),
             ev, goal, fcv, cnt, rdy_ev);
    check("null_done_cycle", ev, 7);
    check("null_count", cnt, 0);
    check("null_no_child", fcv, -1);

    // All slots valid, ready tied high
    run_node(mk(21, 100, 256, 30,1, 31,2, 32,3, 33,4, 34,5, 35,6), ev, goal, fcv, cnt, rdy_ev);
    check("full_first_cv", fcv, 2);
    check("full_done_cycle", ev, 13);
    check("full_count", cnt, 6);

    // Saturation and parent skip
    log_q.delete();
    run_node(mk(22, 0, 16'hFFF0, 4,20, 6,5, 0,1, 16'hFFFF,0, 16'hFFFF,0, 8,15), ev, goal, fcv, cnt, rdy_ev);
    check("sat_count", cnt, 3);
    if (log_q.size() == 3) begin
      check("sat_g_overflow", log_q[0].g, 16'hFFFF);
      check("sat_g_plain", log_q[1].g, 16'hFFF5);
      check("sat_g_exact", log_q[2].g, 16'hFFFF);
    end else begin
      check("sat_n", log_q.size(), 3);
    end

    // Parent id is NULL_ID
    run_node(mk(28, 16'hFFFF, 1, 16'hFFFF,0, 8,2, 16'hFFFF,0, 16'hFFFF,0, 16'hFFFF,0, 16'hFFFF,0),
             ev, goal, fcv, cnt, rdy_ev);
    check("nullpar_count", cnt, 1);

    // Backpressure on the first emit
    log_q.delete();
    child_ready = 1'b0;
    fork
      run_node(mk(23, 0, 5, 40,1, 41,2, 16'hFFFF,0, 16'hFFFF,0, 16'hFFFF,0, 42,3), ev, goal, fcv, cnt, rdy_ev);
      begin
        wait_child_valid("bp_valid_seen");
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_valid_held", child_valid, 1);
          check("bp_id_held", child_id, 40);
          check("bp_g_held", child_g, 6);
        end
        @(posedge clk); #1;
        child_ready = 1'b1;
      end
    join
    check("bp_count", cnt, 3);
    check("bp_n", log_q.size(), 3);
    if (log_q.size() == 3) check("bp_last_g", log_q[2].g, 8);

    // Abort mid-EMIT with a new goal
    n = mk(24, 0, 1, 60,1, 61,1, 62,1, 63,1, 64,1, 65,1);
    @(posedge clk); #1;
    model_node(n);
    node_valid = 1'b1;
    node_data  = n;
    @(posedge clk); #1;
    node_valid = 1'b0;
    wait_child_valid("abort_first_valid");
    @(posedge clk); #1;
    child_ready = 1'b0;
    wait_child_valid("abort_second_valid");
    check("abort_second_id", child_id, 61);
    @(posedge clk); #1;
    start_pulse = 1'b1;
    goal_data   = mk(50, 0, 0, 1,1, 1,1, 1,1, 1,1, 1,1, 1,1);
    @(posedge clk); #1;
    start_pulse = 1'b0;
    check("abort_child_valid_dropped", child_valid, 0);
    check("abort_idle", node_ready, 1);
    check("abort_no_done", expand_done, 0);
    exp_q.delete();
    exp_done_q.delete();
    model_goal  = 16'd50;
    child_ready = 1'b1;
    run_node(mk(25, 0, 0, 70,2, 16'hFFFF,0, 71,3, 16'hFFFF,0, 16'hFFFF,0, 16'hFFFF,0), ev, goal, fcv, cnt, rdy_ev);
    check("post_abort_count", cnt, 2);
    check("post_abort_not_goal", goal, 0);
    run_node(mk(50, 0, 0, 1,1, 2,2, 3,3, 4,4, 5,5, 6,6), ev, goal, fcv, cnt, rdy_ev);
    check("new_goal_latched", goal, 1);

    // Asynchronous reset mid-EMIT
    child_ready = 1'b0;
    n = mk(26, 0, 0, 80,1, 81,1, 82,1, 83,1, 84,1, 85,1);
    @(posedge clk); #1;
    model_node(n);
    node_valid = 1'b1;
    node_data  = n;
    @(posedge clk); #1;
    node_valid = 1'b0;
    wait_child_valid("areset_valid_before");
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("areset_child_valid", child_valid, 0);
    check("areset_child_id", child_id, 0);
    check("areset_node_ready", node_ready, 1);
    exp_q.delete();
    exp_done_q.delete();
    exp_goal    = 0;
    model_goal  = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    reset       = 1'b0;
    child_ready = 1'b1;
    run_node(mk(16'hFFFF, 0, 0, 1,1, 2,2, 3,3, 4,4, 5,5, 6,6), ev, goal, fcv, cnt, rdy_ev);
    check("reset_goal_id_ffff", goal, 1);

    repeat (3) @(negedge clk);
    check("model_drained", exp_q.size() + exp_done_q.size() + exp_goal, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/node_expander.md
# node_expander

Downstream stage of the HPS bridge memory FSM in the A* pathfinding pipeline. It takes one 272-bit node record at a time and compares it against the goal record that the bridge latched on `start_pulse`. If the node is the goal, it reports goal found. Otherwise it walks the six child slots, drops null and back-to-parent edges, and emits one child candidate per valid/ready handshake with its accumulated path cost.

## Interface
- `NUM_CHILDREN`, 6: child slots per node record.
- `NULL_ID`, 16'hFFFF: child id marking an empty slot.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; returns block to IDLE.
- `start_pulse`  in  1  one-cycle pulse from bridge; latches `goal_data` and aborts any expansion.
- `goal_data`  in  272  goal node record (`node_info` layout).
- `node_valid`  in  1  `node_data` is presented.
- `node_data`  in  272  node record to expand.
- `node_ready`  out  1  block can accept a node (high only in IDLE).
- `child_valid`  out  1  child candidate outputs are valid.
- `child_ready`  in  1  consumer accepts the candidate.
- `child_id`  out  16  candidate node id.
- `child_parent_id`  out  16  `node_id` of the expanded node.
- `child_g`  out  16  saturating `current_cost + distance_child_k`.
- `goal_found`  out  1  one-cycle pulse: expanded node id equals goal id.
- `expand_done`  out  1  one-cycle pulse: all six slots processed.
- `child_count`  out  3  number of children emitted; valid while `expand_done` is high.

## Operation
- Registers:
  - goal id, latched from `goal_data.node_id` when `start_pulse` is high.
  - captured node record.
  - slot index, 0–5.
  - emitted counter, 0–6.
- States:
  - **IDLE**
    - `node_ready`=1.
    - If `node_valid` is high, capture `node_data`, clear the index and counter, then go to CHECK.
  - **CHECK** (1 cycle)
    - If `node_id` equals the goal id, pulse `goal_found` and go to IDLE. No children and no `expand_done`.
    - Otherwise go to SCAN.
  - **SCAN** (1 cycle per slot)
    - A slot is valid if its child id ≠ `NULL_ID` and child id ≠ `parent_node_id`.
    - Valid slot: load the `child_*` registers, set `child_valid`, go to EMIT.
    - Invalid slot: if index = 5 go to FINISH, else increment the index and stay in SCAN.
  - **EMIT**
    - Hold all `child_*` outputs stable while `child_ready` is low.
    - On `child_valid && child_ready`: clear `child_valid`, increment the counter, then:
      - index = 5 → FINISH;
      - otherwise increment the index → SCAN.
  - **FINISH**: pulse `expand_done` with `child_count` = counter, then go to IDLE.
- Cost arithmetic:
  - 17-bit sum of `current_cost` and the slot distance.
  - If bit 16 is set, `child_g` = 16'hFFFF.
- `start_pulse` in any state:
  - latches the goal;
  - forces IDLE on the next edge;
  - clears `child_valid`;
  - suppresses any pending `goal_found` or `expand_done` pulse.
- A node whose parent id is `NULL_ID` still skips `NULL_ID` children only once. The null test takes precedence over the parent test.

## Timing
- Reset values:
  - state IDLE, so `node_ready`=1;
  - `child_valid`, `goal_found`, `expand_done` = 0;
  - `child_id`, `child_parent_id`, `child_g`, `child_count` = 0;
  - goal id = 16'hFFFF.
- Node accepted at edge E0:
  - CHECK occupies cycle E0→E1.
  - `goal_found` is high E1→E2, and `node_ready` is high again from E2.
- Non-goal node:
  - Slot 0 is scanned in cycle E1→E2.
  - If slot 0 is valid, `child_valid` rises at E2.
- Per-slot cost:
  - invalid slot: 1 cycle;
  - valid slot: 1 SCAN cycle plus at least 1 EMIT cycle (≥2 total).
- All six slots null: FINISH during E7→E8, `expand_done` high E7→E8, IDLE at E8.
- All six slots valid with `child_ready` tied high: 12 cycles, `expand_done` at E13.
- `child_*` outputs are registered. There is no combinational path from `child_ready` or `node_valid` to any output except `node_ready`, which is decoded from state.
- `reset` asserted mid-EMIT drops `child_valid` immediately (asynchronously).

## Structure
- Shared package `pathfinding_pkg`:
  - the `node_info` packed struct (17 × 16-bit fields, x first);
  - `NULL_ID`;
  - the state enum.
- The bridge FSM and this block both import it.
- One natural sub-module, `sat_add16`: combinational 16+16 → 16 saturating adder.
- Slot selection is a 6:1 mux over struct fields indexed by the slot register.

## Test plan
- Reset, then idle: `node_ready`=1, all other outputs 0, for 5 cycles.
- Goal match:
  - Stimulus: `start_pulse` with goal id 7, then node id 7.
  - Required: `goal_found` is a single-cycle pulse 1 cycle after accept; no `child_valid`, no `expand_done`.
- Mixed slots:
  - Stimulus: node id 3, parent 2, cost 10; children (5,4), (FFFF,x), (2,1), (9,20), (FFFF,x), (11,0); `child_ready`=1.
  - Required: emits (5,g=14), (9,30), (11,10) in order, with `child_parent_id`=3; `expand_done` with `child_count`=3.
- Saturation: cost FFF0, child (4, distance 20) → `child_g`=FFFF.
- Backpressure:
  - Stimulus: `child_ready` low for 4 cycles during the first emit.
  - Required: `child_id`/`child_g` stable and `child_valid` held; resumes correctly after `child_ready` rises.
- Abort:
  - Stimulus: `start_pulse` mid-EMIT.
  - Required: `child_valid` drops, IDLE next cycle, new goal latched; the next node expands normally and its `child_count` excludes the aborted emissions.
